// File: rtl/stopwatch_disp_pkg.sv
// stopwatch_disp_pkg: shared constants for the stopwatch display slice.
//   - active-low 7-segment codes {g,f,e,d,c,b,a} and SEG_BLANK
//   - field saturation limits, conversion length, FSM state enum
//   - seg_code(): BCD digit -> segment pattern
package stopwatch_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int MS_MAX      = 999;
  localparam int SEC_MAX     = 59;
  localparam int MIN_MAX     = 59;
  localparam int CONV_CYCLES = 11;

  typedef enum logic [2:0] {
    IDLE, CONV_MS, CONV_SEC, CONV_MIN, CONV_HOUR, COMMIT
  } disp_state_e;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// stopwatch_display_if: bundles the time fields coming from the stopwatch
// core and the display pins going to the board.
//   master: drives hour_i/min_i/sec_i/ms_i/mode_i, observes display pins
//   slave : the display block (consumes fields, drives an_o/seg_o/dp_o/busy_o)
interface stopwatch_display_if;
  logic [4:0] hour_i;
  logic [5:0] min_i;
  logic [5:0] sec_i;
  logic [9:0] ms_i;
  logic       mode_i;
  logic [7:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;
  logic       busy_o;

  modport master (output hour_i, min_i, sec_i, ms_i, mode_i,
                  input  an_o, seg_o, dp_o, busy_o);
  modport slave  (input  hour_i, min_i, sec_i, ms_i, mode_i,
                  output an_o, seg_o, dp_o, busy_o);
endinterface

// File: rtl/stopwatch_display_bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble converter, one bit per cycle.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : load bin_i (1 cycle)
//   bin_i[9:0]     : binary value, valid in the start cycle
//   done_o         : 1-cycle pulse, 11 cycles after start_i
//   bcd2_o/1_o/0_o : hundreds/tens/ones, valid while done_o is high
module bin2bcd_serial (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [9:0] bin_i,
  output logic       done_o,
  output logic [3:0] bcd2_o,
  output logic [3:0] bcd1_o,
  output logic [3:0] bcd0_o
);

  // {bcd[11:0], bin[9:0]}: binary bits shift up into the BCD nibbles
  logic [21:0] sr;
  logic [3:0]  cnt;
  logic        active;

  function automatic logic [21:0] dd_step(input logic [21:0] v);
    logic [21:0] a;
    a = v;
    for (int i = 0; i < 3; i++) begin
      if (a[10+4*i +: 4] >= 4'd5) a[10+4*i +: 4] = a[10+4*i +: 4] + 4'd3;
    end
    return {a[20:0], 1'b0};
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active <= 1'b0;
      cnt    <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        active <= 1'b1;
        cnt    <= '0;
      end else if (active) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd9) begin
          active <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i)     sr <= {12'd0, bin_i};
    else if (active) sr <= dd_step(sr);
  end

  assign bcd2_o = sr[21:18];
  assign bcd1_o = sr[17:14];
  assign bcd0_o = sr[13:10];

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display: snapshots the stopwatch fields once per scan frame,
// converts them to BCD with one shared serial converter, and scans an
// 8-digit common-anode 7-segment display.
//   clk_i, reset_i    : clock, synchronous active-high reset
//   bus (slave)       : hour_i/min_i/sec_i/ms_i/mode_i in;
//                       an_o (active-low, bit0 rightmost), seg_o, dp_o, busy_o out
//   CLK_DIV           : clk_i cycles per digit (>= 64)
// Build option: STOPWATCH_DISP_LEAD_BLANK_EN blanks a zero tens digit of the
// most significant displayed field (minutes in mode 0, hours in mode 1).
module stopwatch_display
  import stopwatch_disp_pkg::*;
#(
  parameter int CLK_DIV = 12500
) (
  input  logic                clk_i,
  input  logic                reset_i,
  stopwatch_display_if.slave  bus
);

  if (CLK_DIV < 64) begin : g_bad_div
    $error("stopwatch_display: CLK_DIV must be >= 64");
  end

  localparam int PRE_W = $clog2(CLK_DIV);

  logic [PRE_W-1:0] pre;
  logic [2:0]       idx;
  logic             advance, frame_tick, refresh;
  disp_state_e      state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             capture, conv_start, conv_done;
  logic [9:0]       conv_bin;
  logic [3:0]       bcd2, bcd1, bcd0;
  logic [4:0]       hour_s;
  logic [5:0]       min_s, sec_s;
  logic [9:0]       ms_s;
  logic             mode_s;
  logic [3:0]       ms_h, ms_t, ms_o, sec_t, sec_o, min_t, min_o;
  logic [7:0][6:0]  seg_buf, commit_seg;
  logic [7:0]       dp_buf, commit_dp;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  function automatic logic [9:0] sat10(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [5:0] sat6(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // ---- scan prescaler and digit index
  assign advance    = (pre == PRE_W'(CLK_DIV - 1));
  assign frame_tick = advance && (idx == 3'd7);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pre <= '0;
      idx <= '0;
    end else if (advance) begin
      pre <= '0;
      idx <= idx + 3'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // ---- conversion sequencer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    capture    = 1'b0;
    conv_start = 1'b0;
    conv_bin   = '0;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_nxt = CONV_MS;
          capture   = 1'b1;
        end
      end
      CONV_MS, CONV_SEC, CONV_MIN, CONV_HOUR: begin
        conv_start = (cnt == 4'd0);
        if (cnt != 4'(CONV_CYCLES - 1)) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          case (state)
            CONV_MS:  state_nxt = CONV_SEC;
            CONV_SEC: state_nxt = CONV_MIN;
            CONV_MIN: state_nxt = CONV_HOUR;
            default:  state_nxt = COMMIT;
          endcase
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    case (state)
      CONV_MS:   conv_bin = sat10(ms_s, 10'(MS_MAX));
      CONV_SEC:  conv_bin = {4'd0, sat6(sec_s, 6'(SEC_MAX))};
      CONV_MIN:  conv_bin = {4'd0, sat6(min_s, 6'(MIN_MAX))};
      CONV_HOUR: conv_bin = {5'd0, hour_s};
      default:   conv_bin = '0;
    endcase
  end

  bin2bcd_serial u_bcd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .done_o  (conv_done),
    .bcd2_o  (bcd2),
    .bcd1_o  (bcd1),
    .bcd0_o  (bcd0)
  );

  // ---- snapshot and per-field BCD results
  always_ff @(posedge clk_i) begin
    if (capture) begin
      hour_s <= bus.hour_i;
      min_s  <= bus.min_i;
      sec_s  <= bus.sec_i;
      ms_s   <= bus.ms_i;
      mode_s <= bus.mode_i;
    end
  end

  // A field's result arrives on the first cycle of the following state;
  // the hour result is consumed directly during COMMIT.
  always_ff @(posedge clk_i) begin
    if (conv_done) begin
      case (state)
        CONV_SEC:  {ms_h, ms_t, ms_o} <= {bcd2, bcd1, bcd0};
        CONV_MIN:  {sec_t, sec_o}     <= {bcd1, bcd0};
        CONV_HOUR: {min_t, min_o}     <= {bcd1, bcd0};
        default: ;
      endcase
    end
  end

  // ---- digit map and display buffer
  always_comb begin
    commit_seg = {8{SEG_BLANK}};
    commit_dp  = 8'hFF;
    if (!mode_s) begin
      commit_seg[6] = seg_code(min_t);
      commit_seg[5] = seg_code(min_o);
      commit_seg[4] = seg_code(sec_t);
      commit_seg[3] = seg_code(sec_o);
      commit_seg[2] = seg_code(ms_h);
      commit_seg[1] = seg_code(ms_t);
      commit_seg[0] = seg_code(ms_o);
      commit_dp[5]  = 1'b0;
      commit_dp[3]  = 1'b0;
    end else begin
      commit_seg[7] = seg_code(bcd1);
      commit_seg[6] = seg_code(bcd0);
      commit_seg[5] = seg_code(min_t);
      commit_seg[4] = seg_code(min_o);
      commit_seg[3] = seg_code(sec_t);
      commit_seg[2] = seg_code(sec_o);
      commit_dp[6]  = 1'b0;
      commit_dp[4]  = 1'b0;
    end
`ifdef STOPWATCH_DISP_LEAD_BLANK_EN
    if (!mode_s && (min_t == 4'd0)) commit_seg[6] = SEG_BLANK;
    if (mode_s && (bcd1 == 4'd0))   commit_seg[7] = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seg_buf <= {8{SEG_BLANK}};
      dp_buf  <= 8'hFF;
    end else if (state == COMMIT) begin
      seg_buf <= commit_seg;
      dp_buf  <= commit_dp;
    end
  end

  // ---- output registers: reload only on a digit change so a commit
  // never alters the digit that is currently lit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      refresh <= 1'b1;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      refresh <= advance;
      if (refresh) begin
        an_q  <= ~(8'd1 << idx);
        seg_q <= seg_buf[idx];
        dp_q  <= dp_buf[idx];
      end
    end
  end

  assign bus.an_o   = an_q;
  assign bus.seg_o  = seg_q;
  assign bus.dp_o   = dp_q;
  assign bus.busy_o = (state != IDLE);

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

  localparam int DIV = 64;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  stopwatch_display_if bus ();

  stopwatch_display #(.CLK_DIV(DIV)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] eseg [8];
  logic       edp  [8];
  int cur_h, cur_m, cur_s, cur_ms;
  bit cur_md;
  int snap_h, snap_m, snap_s, snap_ms;
  bit snap_md;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference: what each digit position should show for a snapshot.
  task automatic build_expect(input int h, input int m, input int s, input int ms, input bit md);
    int mm, ss, mss;
    mm  = (m > 59) ? 59 : m;
    ss  = (s > 59) ? 59 : s;
    mss = (ms > 999) ? 999 : ms;
    for (int i = 0; i < 8; i++) begin
      eseg[i] = 7'h7F;
      edp[i]  = 1'b1;
    end
    if (!md) begin
      eseg[6] = seg_of(mm / 10);  eseg[5] = seg_of(mm % 10);  edp[5] = 1'b0;
      eseg[4] = seg_of(ss / 10);  eseg[3] = seg_of(ss % 10);  edp[3] = 1'b0;
      eseg[2] = seg_of(mss / 100);
      eseg[1] = seg_of((mss / 10) % 10);
      eseg[0] = seg_of(mss % 10);
`ifdef STOPWATCH_DISP_LEAD_BLANK_EN
      if (mm < 10) eseg[6] = 7'h7F;
`endif
    end else begin
      eseg[7] = seg_of(h / 10);   eseg[6] = seg_of(h % 10);   edp[6] = 1'b0;
      eseg[5] = seg_of(mm / 10);  eseg[4] = seg_of(mm % 10);  edp[4] = 1'b0;
      eseg[3] = seg_of(ss / 10);  eseg[2] = seg_of(ss % 10);
`ifdef STOPWATCH_DISP_LEAD_BLANK_EN
      if (h < 10) eseg[7] = 7'h7F;
`endif
    end
  endtask

  // New contents become visible from d1 of the current frame through d0 of the next.
  task automatic push_frame();
    exp_t e;
    for (int k = 1; k <= 8; k++) begin
      e.an  = ~(8'd1 << (k % 8));
      e.seg = eseg[k % 8];
      e.dp  = edp[k % 8];
      sb.push_back(e);
    end
  endtask

  task automatic push_blank();
    for (int i = 0; i < 8; i++) begin
      eseg[i] = 7'h7F;
      edp[i]  = 1'b1;
    end
    push_frame();
  endtask

  task automatic drive(input int h, input int m, input int s, input int ms, input bit md);
    cur_h = h; cur_m = m; cur_s = s; cur_ms = ms; cur_md = md;
    bus.hour_i = 5'(h);
    bus.min_i  = 6'(m);
    bus.sec_i  = 6'(s);
    bus.ms_i   = 10'(ms);
    bus.mode_i = md;
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
          $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_capture(input bit jit, output bit got);
    int n;
    n   = 0;
    got = 1'b0;
    while (!got && n < 1500) begin
      @(posedge clk_i); #1;
      n++;
      if (bus.busy_o === 1'b1) begin
        got = 1'b1;
        snap_h = cur_h; snap_m = cur_m; snap_s = cur_s; snap_ms = cur_ms; snap_md = cur_md;
      end else if (jit) begin
        drive_rand();
      end
    end
    if (!got) chk("capture_timeout", 0, 1);
  endtask

  task automatic drain_to(input int left);
    int n;
    n = 0;
    while (sb.size() > left && n < 2000) begin
      @(posedge clk_i);
      n++;
    end
    if (sb.size() > left) chk("drain_timeout", sb.size(), left);
  endtask

  task automatic run_test(input int h, input int m, input int s, input int ms,
                          input bit md, input bit jit);
    bit got;
    int bw;
    drain_to(1);
    drive(h, m, s, ms, md);
    wait_capture(jit, got);
    if (got) begin
      bw = 1;
      forever begin
        if (jit) drive_rand();
        @(posedge clk_i); #1;
        if (bus.busy_o !== 1'b1 || bw >= 200) break;
        bw++;
      end
      chk("busy_len", bw, 45);
      build_expect(snap_h, snap_m, snap_s, snap_ms, snap_md);
      push_frame();
    end
  endtask

  // Entered just after the posedge on which reset_i was released.
  task automatic post_reset();
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < 300) begin
      @(posedge clk_i); #1;
      n++;
      if (n == 1) chk("first_an", bus.an_o, 8'hFE);
      if (n == 2) push_blank();
      if (bus.an_o === 8'hFD) found = 1'b1;
    end
    chk("first_step_cycles", n, 65);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"},   bus.an_o,   8'hFF);
    chk({tag, "_seg"},  bus.seg_o,  7'h7F);
    chk({tag, "_dp"},   bus.dp_o,   1);
    chk({tag, "_busy"}, bus.busy_o, 0);
  endtask

  task automatic reset_mid();
    bit got;
    drain_to(1);
    drive_rand();
    wait_capture(1'b0, got);
    repeat (19) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    check_reset_outputs("midrst");
    post_reset();
  endtask

  // Monitor: checks every digit change against the scoreboard and scan timing.
  initial begin
    logic [7:0] last;
    int hold, quiet;
    exp_t e;
    last  = 8'hxx;
    hold  = 0;
    quiet = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) quiet = 0;
      else if (quiet < 10) quiet++;
      hold++;
      if (bus.an_o !== last) begin
        if (last !== 8'hxx && last !== 8'hFF && bus.an_o !== 8'hFF)
          chk($sformatf("hold_an%02h", last), hold, DIV);
        if (quiet >= 2) chk("an_onehot", $countones(~bus.an_o), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("an_o_exp%02h", e.an), bus.an_o, e.an);
          chk($sformatf("seg_o@an%02h", e.an), bus.seg_o, e.seg);
          chk($sformatf("dp_o@an%02h", e.an), bus.dp_o, e.dp);
        end
        last = bus.an_o;
        hold = 0;
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 1'b0);
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    reset_i = 1'b0;
    post_reset();

    run_test(0, 12, 34, 567, 1'b0, 1'b0);
    run_test(0, 0, 63, 1010, 1'b0, 1'b0);
    run_test(23, 45, 6, 0, 1'b1, 1'b0);
    run_test(0, 5, 0, 0, 1'b0, 1'b0);
    run_test(31, 63, 63, 1023, 1'b1, 1'b0);
    run_test(0, 59, 59, 999, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_test($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
               $urandom_range(0, 1023), 1'($urandom_range(0, 1)), 1'(i % 2));
    end

    reset_mid();
    run_test(7, 8, 9, 123, 1'b0, 1'b1);

    drain_to(0);
    repeat (4) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream consumer of the stopwatch counter: takes binary hour/min/sec/ms fields and drives an 8-digit multiplexed common-anode 7-segment display.
- Snapshots the fields once per scan frame so the display is coherent, converts each field to BCD serially, and scans the digits.
- Sits between the stopwatch core and the board pins.

Parameters:
- CLK_DIV, 12500, clk_i cycles per digit (100 MHz / 8 kHz). Must be >= 64; elaboration error otherwise.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- hour_i  in  5  hours, binary
- min_i  in  6  minutes, binary
- sec_i  in  6  seconds, binary
- ms_i  in  10  milliseconds, binary
- mode_i  in  1  0 = MM.SS.mmm, 1 = HH.MM.SS
- an_o  out  8  digit enables, active-low; bit 0 is the rightmost digit
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  out  1  decimal point, active-low
- busy_o  out  1  conversion in progress

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous and active-high.
- Reset values:
  - an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1, busy_o = 0.
  - Prescaler = 0, digit index = 0, display buffer all-blank, FSM in IDLE.
- Prescaler: counts 0..CLK_DIV-1. At CLK_DIV-1 the digit index advances (7 wraps to 0).
- Output timing: an_o, seg_o and dp_o are registered and reflect the new index one cycle after the advance. Exactly one an_o bit is low outside reset.
- frame_tick: the advance from index 7 to 0.
- FSM states: IDLE, CONV_MS, CONV_SEC, CONV_MIN, CONV_HOUR, COMMIT.
  - IDLE to CONV_MS on frame_tick. On that cycle all inputs and mode_i are captured into snapshot registers; later input changes are ignored until the next snapshot.
  - Each CONV state takes 11 cycles (1 load, 10 shift-add-3), then moves to the next field.
  - COMMIT takes 1 cycle: it writes all digits into the display buffer atomically and returns to IDLE.
  - busy_o is high from the cycle after capture through COMMIT: 45 cycles.
- Buffer visibility: the new buffer becomes visible at the next digit advance after COMMIT. The first frame after reset shows blanks.
- frame_tick while busy: the snapshot is skipped. This cannot happen when CLK_DIV >= 64.
- Saturation before conversion: ms > 999 shows 999; sec or min > 59 shows 59; hour is shown as-is (00-31).
- Digit map, mode 0:
  - d7 blank.
  - d6-d5 minutes, dp on d5.
  - d4-d3 seconds, dp on d3.
  - d2-d0 milliseconds (hundreds, tens, ones).
- Digit map, mode 1:
  - d7-d6 hours, dp on d6.
  - d5-d4 minutes, dp on d4.
  - d3-d2 seconds.
  - d1-d0 blank.
- Segment codes (active-low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19.
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - blank = 7F; dp off = 1.
- Reset mid-conversion: the FSM aborts to IDLE, the buffer clears, and outputs return to their reset values on the next cycle.

Optional Feature:
- STOPWATCH_DISP_LEAD_BLANK_EN
- Defined: the tens digit of the most significant displayed field (minutes in mode 0, hours in mode 1) is blanked when zero. This is applied at COMMIT.
- Undefined: leading zeros are always shown.

Decomposition:
- Package stopwatch_disp_pkg holds:
  - the segment code constants and SEG_BLANK;
  - MS_MAX = 999, SEC_MAX = 59, MIN_MAX = 59;
  - the FSM state enum;
  - CONV_CYCLES = 11.
- Sub-module bin2bcd_serial:
  - 10-bit input, three 4-bit BCD outputs;
  - start/done handshake: done pulses for 1 cycle, 11 cycles after start;
  - reused once per field.

Test Plan:
- Basic digits. CLK_DIV = 64, mode 0, min = 12, sec = 34, ms = 567; wait for a frame plus commit plus one frame. Expect:
  - d6 = 79, d5 = 24 with dp_o = 0, d3 with dp_o = 0;
  - d2 = 12, d1 = 02, d0 = 78;
  - d7 = 7F.
- Scan timing. After reset, an_o steps FE, FD, FB, ... 7F, FE, each held exactly 64 cycles; the first step lands 65 cycles after reset release.
- Saturation and mode 1:
  - ms = 1010, sec = 63 shows 999 and 59.
  - mode 1, hour = 23 gives d7 = 24, d6 = 30 with dp.
- Coherency. Change ms every cycle during a frame; the displayed value equals the value at frame_tick. busy_o is high for exactly 45 cycles.
- Reset mid-conversion. Assert reset_i for 1 cycle at capture + 20. The next cycle shows an_o = FF, seg_o = 7F, busy_o = 0; the following frame shows blanks.
- Lead blanking. With STOPWATCH_DISP_LEAD_BLANK_EN defined, min = 5 in mode 0 gives d6 = 7F and d5 = 12. Without it, d6 = 40.
